// File: rtl/io_pins_sampler_pkg.sv
// io_pins_sampler_pkg
//   Shared constants for the GPIO readback sampler:
//   - bank geometry
//   - serial register addresses of the sampler registers
//   - edge-config record layout
//   - arming-delay helper
//   Optional build macro: IO_SAMPLER_DEBOUNCE_EN adds the debounce filter,
//   which lengthens the arming delay.
package io_pins_sampler_pkg;

    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 16;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;

    // Register map of the sampler, next to the output-enable registers.
    localparam logic [ADDR_W-1:0] FR_IO_EDGE_CFG   = 7'h30;
    localparam logic [ADDR_W-1:0] FR_IO_CHG_CLR_01 = 7'h31;
    localparam logic [ADDR_W-1:0] FR_IO_CHG_CLR_23 = 7'h32;
    localparam logic [ADDR_W-1:0] FR_IO_SNAP       = 7'h33;

    // Layout of FR_IO_EDGE_CFG data[7:0].
    typedef struct packed {
        logic [NUM_BANKS-1:0] fall_en;
        logic [NUM_BANKS-1:0] rise_en;
    } edge_cfg_t;

    // The synchroniser plus the prev register needs 3 cycles to hold
    // real pin levels. The debounce filter starts at 0, so it needs
    // DEBOUNCE_CYCLES more cycles before it can follow a pin that was
    // already high at reset.
    localparam int SYNC_ARM_CYCLES = 3;

    function automatic int arm_cycles(input bit debounce_en, input int debounce_cycles);
        return debounce_en ? SYNC_ARM_CYCLES + debounce_cycles : SYNC_ARM_CYCLES;
    endfunction

endpackage

// File: rtl/io_pins_sampler_if.sv
// io_pins_sampler_if
//   Serial register write bus shared with the output-enable block.
//   serial_addr   : register address
//   serial_data   : write data
//   serial_strobe : one-cycle write strobe
//   Modports:
//   - master : the host side that drives the writes
//   - slave  : the sampler side that receives them
interface io_pins_sampler_if;
    import io_pins_sampler_pkg::*;

    logic [ADDR_W-1:0] serial_addr;
    logic [DATA_W-1:0] serial_data;
    logic              serial_strobe;

    modport master (output serial_addr, output serial_data, output serial_strobe);
    modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/io_sync_edge.sv
// io_sync_edge
//   One 16-bit pin bank. The bank contains:
//   - a two-flop synchroniser
//   - an optional debounce filter
//   - the prev register
//   - sticky change flags with per-bank rise/fall enables and a
//     write-1-to-clear mask
//   Ports:
//     clock, reset  : system clock, asynchronous active-high reset
//     pins          : raw asynchronous pin values
//     armed         : edge detection allowed
//     rise_en       : bank rise enable
//     fall_en       : bank fall enable
//     clr           : clear mask, one bit per pin
//     level         : current (synchronised or filtered) level
//     chg           : sticky change flags
//   Optional build macro: IO_SAMPLER_DEBOUNCE_EN adds the filter. Each bit
//   gets a 4-bit counter between the synchroniser and the edge detector.
module io_sync_edge
    import io_pins_sampler_pkg::*;
#(
    parameter int W = BANK_W
`ifdef IO_SAMPLER_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 8
`endif
)
(
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] pins,
    input  logic         armed,
    input  logic         rise_en,
    input  logic         fall_en,
    input  logic [W-1:0] clr,
    output logic [W-1:0] level,
    output logic [W-1:0] chg
);

    logic [W-1:0] sync1, sync2, prev, rise, fall, set;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

`ifdef IO_SAMPLER_DEBOUNCE_EN
    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]      filt;
    logic [W-1:0][3:0] cnt;

    // The filtered bit flips on the DEBOUNCE_CYCLES-th consecutive
    // differing sample. Any agreeing sample restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt <= '0;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        filt[i] <= sync2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    assign rise = level & ~prev;
    assign fall = ~level & prev;
    assign set  = armed ? ((rise & {W{rise_en}}) | (fall & {W{fall_en}})) : '0;

    // Set is OR-ed in after the clear, so a new event that arrives in the
    // same cycle as a clear is not lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev <= '0;
            chg  <= '0;
        end else begin
            prev <= level;
            chg  <= (chg & ~clr) | set;
        end
    end

endmodule

// File: rtl/io_pins_sampler.sv
// io_pins_sampler
//   GPIO readback: samples the four 16-bit pin banks, latches per-pin
//   edge events, and provides coherent snapshots for the host readback mux.
//   Ports:
//     clock, reset   : system clock, asynchronous active-high reset
//     io_0..io_3     : pin banks (asynchronous to clock)
//     bus            : serial register write bus (slave modport)
//     snap_01/23     : {io_1,io_0} / {io_3,io_2} snapshot, taken on FR_IO_SNAP
//     chg_01/23      : sticky change flags of the same pairs
//     io_irq         : OR of all change flags, registered
//   Optional build macro: IO_SAMPLER_DEBOUNCE_EN enables the debounce
//   filter (DEBOUNCE_CYCLES, 2..15).
module io_pins_sampler
    import io_pins_sampler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic [BANK_W-1:0]   io_0,
    input  logic [BANK_W-1:0]   io_1,
    input  logic [BANK_W-1:0]   io_2,
    input  logic [BANK_W-1:0]   io_3,
    io_pins_sampler_if.slave    bus,
    output logic [2*BANK_W-1:0] snap_01,
    output logic [2*BANK_W-1:0] snap_23,
    output logic [2*BANK_W-1:0] chg_01,
    output logic [2*BANK_W-1:0] chg_23,
    output logic                io_irq
);

`ifdef IO_SAMPLER_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    localparam int         ARM_CYCLES = arm_cycles(DEB_EN, DEBOUNCE_CYCLES);
    localparam logic [4:0] ARM_LAST   = 5'(ARM_CYCLES);

    logic [NUM_BANKS-1:0][BANK_W-1:0] pins, level, chg, clr, snap;
    logic [4:0] arm_cnt;
    logic       armed;
    edge_cfg_t  cfg;
    logic       wr_cfg, wr_clr01, wr_clr23, wr_snap;

    assign pins = {io_3, io_2, io_1, io_0};

    assign wr_cfg   = bus.serial_strobe && (bus.serial_addr == FR_IO_EDGE_CFG);
    assign wr_clr01 = bus.serial_strobe && (bus.serial_addr == FR_IO_CHG_CLR_01);
    assign wr_clr23 = bus.serial_strobe && (bus.serial_addr == FR_IO_CHG_CLR_23);
    assign wr_snap  = bus.serial_strobe && (bus.serial_addr == FR_IO_SNAP);

    // Edge detection stays off until the pipeline holds real post-reset
    // levels. Otherwise a pin that is high at reset would look like a rise.
    assign armed = (arm_cnt == ARM_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 5'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       cfg <= '0;
        else if (wr_cfg) cfg <= bus.serial_data[7:0];
    end

    always_comb begin
        clr = '0;
        if (wr_clr01) clr[1:0] = bus.serial_data;
        if (wr_clr23) clr[3:2] = bus.serial_data;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        io_sync_edge #(
            .W(BANK_W)
`ifdef IO_SAMPLER_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_bank (
            .clock   (clock),
            .reset   (reset),
            .pins    (pins[b]),
            .armed   (armed),
            .rise_en (cfg.rise_en[b]),
            .fall_en (cfg.fall_en[b]),
            .clr     (clr[b]),
            .level   (level[b]),
            .chg     (chg[b])
        );
    end

    // All 64 bits are taken on the same edge, so each half is coherent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        snap <= '0;
        else if (wr_snap) snap <= level;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) io_irq <= 1'b0;
        else       io_irq <= |chg;
    end

    assign snap_01 = snap[1:0];
    assign snap_23 = snap[3:2];
    assign chg_01  = chg[1:0];
    assign chg_23  = chg[3:2];

endmodule
